// File: rtl/mips_pkg.sv
// Shared pipeline constants: datapath width, register-index width and the
// hard-wired zero register index used by every stage.
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// Writeback-to-register-file and decode read-port signals. There is no
// handshake: every field is sampled or produced in the cycle it is presented.
interface wb_regfile_if #(
  parameter int DATA_W = mips_pkg::DATA_W
);
  import mips_pkg::*;

  logic [DATA_W-1:0]     WB_aluresult;
  logic [DATA_W-1:0]     WB_memread;
  logic [REG_ADDR_W-1:0] WB_writereg;
  logic                  WB_memtoreg;
  logic                  WB_regwrite;
  logic [REG_ADDR_W-1:0] ID_rs;
  logic [REG_ADDR_W-1:0] ID_rt;
  logic [DATA_W-1:0]     ID_rsdata;
  logic [DATA_W-1:0]     ID_rtdata;
  logic [DATA_W-1:0]     WB_writedata;

  modport master (
    output WB_aluresult, WB_memread, WB_writereg, WB_memtoreg, WB_regwrite,
    output ID_rs, ID_rt,
    input  ID_rsdata, ID_rtdata, WB_writedata
  );

  modport slave (
    input  WB_aluresult, WB_memread, WB_writereg, WB_memtoreg, WB_regwrite,
    input  ID_rs, ID_rt,
    output ID_rsdata, ID_rtdata, WB_writedata
  );
endinterface

// File: rtl/wb_mux.sv
// Writeback select: load data when mem_to_reg is set, otherwise ALU result.
module wb_mux #(
  parameter int W = 32
) (
  input  logic         mem_to_reg,
  input  logic [W-1:0] alu_result,
  input  logic [W-1:0] mem_data,
  output logic [W-1:0] write_data
);
  assign write_data = mem_to_reg ? mem_data : alu_result;
endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback select and same-cycle write-to-read bypass.
// Register 0 has no storage; it reads as zero on both ports.
module wb_regfile #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int NREGS  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);
  import mips_pkg::*;

  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] regs [1:NREGS-1];
  logic              wr_en;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  function automatic logic in_range(input logic [REG_ADDR_W-1:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  wb_mux #(.W(DATA_W)) u_wb_mux (
    .mem_to_reg (bus.WB_memtoreg),
    .alu_result (bus.WB_aluresult),
    .mem_data   (bus.WB_memread),
    .write_data (write_data)
  );

  assign bus.WB_writedata = write_data;

  assign wr_en = bus.WB_regwrite && (bus.WB_writereg != REG_ZERO) &&
                 in_range(bus.WB_writereg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[bus.WB_writereg] <= write_data;
    end
  end

  // Reset forces zero on both ports and blocks the bypass path.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rst_n && bus.ID_rs != REG_ZERO && in_range(bus.ID_rs)) begin
      rs_data = (wr_en && bus.ID_rs == bus.WB_writereg) ? write_data : regs[bus.ID_rs];
    end
    if (rst_n && bus.ID_rt != REG_ZERO && in_range(bus.ID_rt)) begin
      rt_data = (wr_en && bus.ID_rt == bus.WB_writereg) ? write_data : regs[bus.ID_rt];
    end
  end

  assign bus.ID_rsdata = rs_data;
  assign bus.ID_rtdata = rt_data;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed and random checks of the writeback register file: select, write,
// bypass, register 0 and asynchronous reset behaviour.
module tb_wb_regfile;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  int checks   = 0;
  int failures = 0;

  task automatic push_exp(input logic [31:0] rs_e, input logic [31:0] rt_e,
                          input logic [31:0] wd_e);
    exp_q.push_back(rs_e);
    exp_q.push_back(rt_e);
    exp_q.push_back(wd_e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.WB_regwrite  = we;
    bus.WB_writereg  = wr;
    bus.WB_memtoreg  = m2r;
    bus.WB_aluresult = alu;
    bus.WB_memread   = mem;
    bus.ID_rs        = rs;
    bus.ID_rt        = rt;
  endtask

  task automatic sample(input string tag);
    #1;
    check({tag, ".rs"}, bus.ID_rsdata);
    check({tag, ".rt"}, bus.ID_rtdata);
    check({tag, ".wd"}, bus.WB_writedata);
  endtask

  // Advance one cycle, applying the write the bench expects at the edge.
  task automatic step();
    @(posedge clk);
    if (rst_n && bus.WB_regwrite && bus.WB_writereg != 5'd0)
      model[bus.WB_writereg] = bus.WB_memtoreg ? bus.WB_memread : bus.WB_aluresult;
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    logic [31:0] sel;
    sel = bus.WB_memtoreg ? bus.WB_memread : bus.WB_aluresult;
    if (!rst_n || idx == 5'd0) return 32'h0;
    if (bus.WB_regwrite && bus.WB_writereg == idx) return sel;
    return model[idx];
  endfunction

  initial begin
    logic        r_we, r_m2r;
    logic [4:0]  r_wr, r_rs, r_rt;
    logic [31:0] r_alu, r_mem;

    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset: reads forced to zero, bypass blocked, select still live.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b0, 32'h0000CAFE, 32'h0, 5'd5, 5'd0);
    push_exp(32'h0, 32'h0, 32'h0000CAFE);
    sample("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
      push_exp(32'h0, 32'h0, 32'h0);
      sample("post_reset_read");
    end

    // Write r5 via ALU path, bypass in the same cycle, stored value next.
    drive(1'b1, 5'd5, 1'b0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd1);
    push_exp(32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    sample("wr5_bypass");
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd5, 5'd5);
    push_exp(32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    sample("rd5_stored");

    // Load path selected over ALU result.
    drive(1'b1, 5'd9, 1'b1, 32'hFFFFFFFF, 32'h12345678, 5'd0, 5'd5);
    push_exp(32'h0, 32'hDEADBEEF, 32'h12345678);
    sample("wr9_load");
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd9, 5'd9);
    push_exp(32'h12345678, 32'h12345678, 32'h0);
    sample("rd9_stored");

    // Both ports bypass the same register.
    drive(1'b1, 5'd7, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7);
    push_exp(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    sample("wr7_dual_bypass");
    step();

    // Register 0 ignores writes and never bypasses.
    drive(1'b1, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    push_exp(32'h0, 32'h0, 32'hFFFFFFFF);
    sample("wr0_same");
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7);
    push_exp(32'h0, 32'hA5A5A5A5, 32'h0);
    sample("rd0_after");

    // Write enable low: no change and no bypass.
    drive(1'b0, 5'd3, 1'b0, 32'h1, 32'h0, 5'd3, 5'd3);
    push_exp(32'h0, 32'h0, 32'h1);
    sample("nowe_r3");
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3);
    push_exp(32'h0, 32'h0, 32'h0);
    sample("nowe_r3_after");

    // Independent bypass: rs hits the write, rt reads stored value.
    drive(1'b1, 5'd5, 1'b0, 32'h0BADF00D, 32'h0, 5'd5, 5'd9);
    push_exp(32'h0BADF00D, 32'h12345678, 32'h0BADF00D);
    sample("split_bypass");
    step();

    // Mid-cycle reset clears storage at once and drops the coincident write.
    drive(1'b1, 5'd4, 1'b0, 32'h55, 32'h0, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd4, 1'b0, 32'h99, 32'h0, 5'd4, 5'd5);
    push_exp(32'h99, 32'h0BADF00D, 32'h99);
    sample("pre_reset");
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    push_exp(32'h0, 32'h0, 32'h99);
    sample("async_reset");
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd4, 5'd5);
    push_exp(32'h0, 32'h0, 32'h0);
    sample("after_reset");
    drive(1'b1, 5'd4, 1'b0, 32'h77, 32'h0, 5'd1, 5'd2);
    push_exp(32'h0, 32'h0, 32'h77);
    sample("first_write");
    step();
    drive(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 5'd4, 5'd0);
    push_exp(32'h77, 32'h0, 32'h0);
    sample("first_write_rd");

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_m2r = 1'($urandom_range(0, 1));
      r_wr  = 5'($urandom_range(0, 31));
      r_rs  = (n % 3 == 0) ? r_wr : 5'($urandom_range(0, 31));
      r_rt  = 5'($urandom_range(0, 31));
      r_alu = $urandom;
      r_mem = $urandom;
      drive(r_we, r_wr, r_m2r, r_alu, r_mem, r_rs, r_rt);
      push_exp(exp_read(r_rs), exp_read(r_rt), r_m2r ? r_mem : r_alu);
      sample("random");
      step();
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL leftover_expect observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning architectural register count (register 0 included).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port WB_aluresult, input, 32 bits: ALU result from the MEM/WB register.
REQ-006 The block SHALL have port WB_memread, input, 32 bits: load data from the MEM/WB register.
REQ-007 The block SHALL have port WB_writereg, input, 5 bits: destination register index.
REQ-008 The block SHALL have port WB_memtoreg, input, 1 bit: 1 selects load data, 0 selects ALU result.
REQ-009 The block SHALL have port WB_regwrite, input, 1 bit: write enable for this writeback.
REQ-010 The block SHALL have port ID_rs, input, 5 bits: read port A index.
REQ-011 The block SHALL have port ID_rt, input, 5 bits: read port B index.
REQ-012 The block SHALL have port ID_rsdata, output, 32 bits: read port A data.
REQ-013 The block SHALL have port ID_rtdata, output, 32 bits: read port B data.
REQ-014 The block SHALL have port WB_writedata, output, 32 bits: selected writeback value, also routed to EX forwarding.

Function
REQ-015 WB_writedata SHALL equal WB_memread when WB_memtoreg=1, else WB_aluresult; it is combinational with zero latency.
REQ-016 On each rising clk edge with rst_n=1, WB_regwrite=1 and WB_writereg!=0, register[WB_writereg] SHALL take WB_writedata.
REQ-017 A write with WB_writereg=0 SHALL be discarded; register 0 SHALL read as 0 at all times.
REQ-018 With WB_regwrite=0, no register SHALL change.
REQ-019 Reads SHALL be combinational: ID_rsdata=register[ID_rs] and ID_rtdata=register[ID_rt].
REQ-020 Bypass: when WB_regwrite=1, WB_writereg!=0 and WB_writereg equals the read index, that port SHALL return WB_writedata in the same cycle rather than the stored value.
REQ-021 Both read ports SHALL bypass independently; rs=rt=WB_writereg returns WB_writedata on both ports.
REQ-022 Index 0 on a read port SHALL return 0 even when WB_writereg=0 and WB_regwrite=1.
REQ-023 After a write, the stored value SHALL be visible on the read ports from the next cycle without bypass.

Reset
REQ-024 While rst_n=0, registers 1..NREGS-1 SHALL be cleared to 0 immediately, independent of clk.
REQ-025 While rst_n=0, ID_rsdata and ID_rtdata SHALL be 0 with bypass suppressed, and no write SHALL occur.
REQ-026 WB_writedata SHALL remain a pure function of its inputs during reset.
REQ-027 Reset asserted mid-operation SHALL discard any write coincident with the reset edge; the first write takes effect on the first rising edge with rst_n=1.

Structure
REQ-028 DATA_W, REG_ADDR_W (5) and the constant REG_ZERO (5'd0) SHALL live in shared package mips_pkg, which is used by all pipeline stages.
REQ-029 The writeback 2:1 select SHALL be a sub-module, wb_mux, instantiated once, with its output driving both the write port and WB_writedata.
REQ-030 Register 0 SHALL NOT be implemented as storage.

Verification
REQ-031 Apply reset, then read all indices -> all read 0; write reg 5=32'hDEADBEEF (memtoreg=0) -> next cycle ID_rs=5 reads 32'hDEADBEEF.
REQ-032 memtoreg=1, memread=32'h12345678, aluresult=32'hFFFFFFFF, writereg=9 -> WB_writedata=32'h12345678 and reg 9=32'h12345678.
REQ-033 Same-cycle write reg 7=32'hA5A5A5A5 with ID_rs=ID_rt=7 -> both ports 32'hA5A5A5A5 in that cycle.
REQ-034 Write reg 0=32'hFFFFFFFF with ID_rs=0 -> ID_rsdata=0 in that cycle and afterwards.
REQ-035 regwrite=0, writereg=3, aluresult=32'h1 -> reg 3 unchanged and no bypass.
REQ-036 Load reg 4=32'h55, then assert rst_n=0 between clock edges -> reg 4 reads 0 immediately; a write coincident with reset is lost.
